// File: rtl/hello_eth_pkg.sv
// Shared types, constants and small helpers for the hello_eth frame generator.
package hello_eth_pkg;

   typedef enum logic [2:0] {
      StPhyRst,
      StWait,
      StPreamble,
      StSfd,
      StHeader,
      StPayload,
      StFcs,
      StIfg
   } state_e;

   localparam logic [7:0] PreambleByte = 8'h55;
   localparam logic [7:0] SfdByte      = 8'hD5;
   localparam logic [7:0] BcastByte    = 8'hFF;

   // Byte offsets within the frame, counted from the first preamble byte.
   localparam logic [15:0] OffPreamble = 16'd0;
   localparam logic [15:0] OffSfd      = 16'd7;
   localparam logic [15:0] OffDst      = 16'd8;
   localparam logic [15:0] OffSrc      = 16'd14;
   localparam logic [15:0] OffType     = 16'd20;
   localparam logic [15:0] OffPayload  = 16'd22;
   localparam logic [15:0] OffCnt      = 16'd31;
   localparam logic [15:0] OffPad      = 16'd35;
   localparam logic [15:0] OffFcs      = 16'd68;
   localparam logic [15:0] FrameLen    = 16'd72;
   localparam logic [15:0] IfgSlots    = 16'd12;

   localparam logic [31:0] CrcPoly = 32'h04C1_1DB7;
   localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // The CRC is computed LSB first, so the shift register uses the bit-reversed polynomial.
   localparam logic [31:0] CrcPolyRefl = reflect32(CrcPoly);

   // "Hello ETH"
   function automatic logic [7:0] greeting_byte(input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'h48;
         4'd1:    b = 8'h65;
         4'd2:    b = 8'h6C;
         4'd3:    b = 8'h6C;
         4'd4:    b = 8'h6F;
         4'd5:    b = 8'h20;
         4'd6:    b = 8'h45;
         4'd7:    b = 8'h54;
         4'd8:    b = 8'h48;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Field that the byte at a given frame offset belongs to; past the end is gap.
   function automatic state_e field_state(input logic [15:0] idx);
      state_e st;
      if (idx < OffSfd) begin
         st = StPreamble;
      end else if (idx < OffDst) begin
         st = StSfd;
      end else if (idx < OffPayload) begin
         st = StHeader;
      end else if (idx < OffFcs) begin
         st = StPayload;
      end else if (idx < FrameLen) begin
         st = StFcs;
      end else begin
         st = StIfg;
      end
      return st;
   endfunction

endpackage

// File: rtl/hello_eth_crc32_d8.sv
// One byte step of the reflected IEEE CRC-32, data consumed LSB first.
module crc32_d8
   import hello_eth_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] c;

   // Eight serial shifts unrolled into one combinational step.
   always_comb begin
      c = crc_i ^ {24'h000000, data_i};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CrcPolyRefl) : (c >> 1);
      end
      crc_o = c;
   end

endmodule

// File: rtl/hello_eth.sv
// Board bring-up top: releases the PHY reset, then periodically broadcasts a
// fixed Ethernet II greeting frame with a frame counter and FCS on GMII.
module hello_eth
   import hello_eth_pkg::*;
#(
   parameter logic [47:0] SRC_MAC        = 48'h10E2_D500_0000,
   parameter logic [15:0] ETHERTYPE      = 16'h88B5,
   parameter int unsigned CLK_DIV        = 2,
   parameter int unsigned PHY_RST_CYCLES = 32,
   parameter int unsigned START_SLOTS    = 8,
   parameter int unsigned FRAME_PERIOD   = 2000,
   parameter logic [31:0] CNT_INIT       = 32'h0000_0000
) (
   input  logic       clk200_p,
   input  logic       clk200_n,
   input  logic       cpu_reset,
   input  logic       serial_rx,
   input  logic       serial_cts,
   input  logic       serial_rts,
   output logic       serial_tx,
   output logic       eth_rst_n,
   output logic       eth_clocks_gtx,
   output logic       eth_tx_en,
   output logic [7:0] eth_tx_data
);

   if (CLK_DIV != 2) begin : g_clk_div_check
      $error("hello_eth only supports CLK_DIV == 2");
   end

   // Pins kept for board compatibility only.
   logic unused_pins;
   assign unused_pins = ^{clk200_n, serial_rx, serial_cts, serial_rts};
   assign serial_tx   = 1'b1;

   logic [1:0]  rst_sync_q;
   logic        rst_n;
   logic        gtx_q;
   state_e      state_q;
   logic [15:0] phy_cnt_q;
   logic [15:0] slot_cnt_q;
   logic        eth_rst_n_q;
   logic        tx_en_q;
   logic [7:0]  tx_data_q;
   logic [31:0] crc_q;
   logic [31:0] frame_cnt_q;

   logic [7:0]  byte_d;
   logic [31:0] crc_d;
   logic [5:0]  byte_off;
   logic [47:0] mac_sh;
   logic [15:0] type_sh;
   logic [31:0] cnt_sh;
   logic [31:0] fcs_sh;

   // Asynchronous assert, two-flop synchronised release.
   always_ff @(posedge clk200_p or negedge cpu_reset) begin
      if (!cpu_reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   // GMII transmit clock: low in the first cycle of each byte slot, high in the second.
   always_ff @(posedge clk200_p or negedge rst_n) begin
      if (!rst_n) begin
         gtx_q <= 1'b0;
      end else begin
         gtx_q <= ~gtx_q;
      end
   end

   // Byte to put on the wire for frame offset slot_cnt_q.
   always_comb begin
      byte_d   = 8'h00;
      byte_off = '0;
      mac_sh   = '0;
      type_sh  = '0;
      cnt_sh   = '0;
      fcs_sh   = '0;
      if (slot_cnt_q < OffSfd) begin
         byte_d = PreambleByte;
      end else if (slot_cnt_q < OffDst) begin
         byte_d = SfdByte;
      end else if (slot_cnt_q < OffSrc) begin
         byte_d = BcastByte;
      end else if (slot_cnt_q < OffType) begin
         byte_off = 6'(slot_cnt_q - OffSrc);
         mac_sh   = SRC_MAC << {byte_off, 3'b000};
         byte_d   = mac_sh[47:40];
      end else if (slot_cnt_q < OffPayload) begin
         byte_off = 6'(slot_cnt_q - OffType);
         type_sh  = ETHERTYPE << {byte_off, 3'b000};
         byte_d   = type_sh[15:8];
      end else if (slot_cnt_q < OffCnt) begin
         byte_off = 6'(slot_cnt_q - OffPayload);
         byte_d   = greeting_byte(byte_off[3:0]);
      end else if (slot_cnt_q < OffPad) begin
         byte_off = 6'(slot_cnt_q - OffCnt);
         cnt_sh   = frame_cnt_q << {byte_off, 3'b000};
         byte_d   = cnt_sh[31:24];
      end else if (slot_cnt_q < OffFcs) begin
         byte_d = 8'h00;
      end else if (slot_cnt_q < FrameLen) begin
         // FCS goes out complemented, low byte first.
         byte_off = 6'(slot_cnt_q - OffFcs);
         fcs_sh   = (~crc_q) >> {byte_off, 3'b000};
         byte_d   = fcs_sh[7:0];
      end
   end

   crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i (byte_d),
      .crc_o  (crc_d)
   );

   // Main sequencer; slot_cnt_q counts byte slots since the current frame start.
   always_ff @(posedge clk200_p or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StPhyRst;
         phy_cnt_q   <= '0;
         slot_cnt_q  <= '0;
         eth_rst_n_q <= 1'b0;
         tx_en_q     <= 1'b0;
         tx_data_q   <= 8'h00;
         crc_q       <= CrcInit;
         frame_cnt_q <= CNT_INIT;
      end else begin
         case (state_q)
            StPhyRst: begin
               if (phy_cnt_q == 16'(PHY_RST_CYCLES - 1)) begin
                  eth_rst_n_q <= 1'b1;
                  state_q     <= StWait;
                  // Preload so the first frame starts START_SLOTS slots from here.
                  slot_cnt_q  <= 16'(FRAME_PERIOD - START_SLOTS + 1);
               end else begin
                  phy_cnt_q <= phy_cnt_q + 16'd1;
               end
            end
            StWait: begin
               if (gtx_q) begin
                  if (slot_cnt_q == 16'(FRAME_PERIOD)) begin
                     state_q    <= StPreamble;
                     tx_en_q    <= 1'b1;
                     tx_data_q  <= PreambleByte;
                     crc_q      <= CrcInit;
                     slot_cnt_q <= OffPreamble + 16'd1;
                  end else begin
                     slot_cnt_q <= slot_cnt_q + 16'd1;
                  end
               end
            end
            StIfg: begin
               if (gtx_q) begin
                  slot_cnt_q <= slot_cnt_q + 16'd1;
                  if (slot_cnt_q == FrameLen + IfgSlots - 16'd1) begin
                     state_q <= StWait;
                  end
               end
            end
            default: begin
               // Frame fields; the CRC absorbs each byte in the slot it is driven.
               if (gtx_q) begin
                  slot_cnt_q <= slot_cnt_q + 16'd1;
                  state_q    <= field_state(slot_cnt_q);
                  tx_data_q  <= byte_d;
                  tx_en_q    <= (slot_cnt_q < FrameLen);
                  if (slot_cnt_q >= OffDst && slot_cnt_q < OffFcs) begin
                     crc_q <= crc_d;
                  end
                  if (slot_cnt_q == FrameLen) begin
                     frame_cnt_q <= frame_cnt_q + 32'd1;
                  end
               end
            end
         endcase
      end
   end

   assign eth_rst_n      = eth_rst_n_q;
   assign eth_clocks_gtx = gtx_q;
   assign eth_tx_en      = tx_en_q;
   assign eth_tx_data    = tx_data_q;

endmodule

// File: tb/tb_hello_eth.sv
// Directed bench for hello_eth: startup timing, frame contents and FCS, frame
// spacing, counter wrap (second instance with preloaded counter) and reset mid-frame.
module tb_hello_eth;

   logic clk = 1'b0;
   logic clk_n;
   logic cpu_reset;
   logic rst_w;
   logic sel_w;

   logic       serial_tx,   eth_rst_n,   gtx,   en;
   logic [7:0] data;
   logic       serial_tx_w, eth_rst_n_w, gtx_w, en_w;
   logic [7:0] data_w;

   logic       mon_rst_n, mon_gtx, mon_en;
   logic [7:0] mon_data;

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int frm_start = 0;

   logic [7:0] got_frm [72];
   logic [7:0] exp_frm [72];
   logic [7:0] hello_str [9] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h45, 8'h54, 8'h48};
   logic [7:0] src_mac [6]   = '{8'h10, 8'hE2, 8'hD5, 8'h00, 8'h00, 8'h00};

   always #5 clk = ~clk;
   assign clk_n = ~clk;

   always @(negedge clk) cyc <= cyc + 1;

   hello_eth dut (
      .clk200_p       (clk),
      .clk200_n       (clk_n),
      .cpu_reset      (cpu_reset),
      .serial_rx      (1'b1),
      .serial_cts     (1'b1),
      .serial_rts     (1'b1),
      .serial_tx      (serial_tx),
      .eth_rst_n      (eth_rst_n),
      .eth_clocks_gtx (gtx),
      .eth_tx_en      (en),
      .eth_tx_data    (data)
   );

   hello_eth #(
      .FRAME_PERIOD (100),
      .CNT_INIT     (32'hFFFF_FFFF)
   ) dut_w (
      .clk200_p       (clk),
      .clk200_n       (clk_n),
      .cpu_reset      (rst_w),
      .serial_rx      (1'b1),
      .serial_cts     (1'b1),
      .serial_rts     (1'b1),
      .serial_tx      (serial_tx_w),
      .eth_rst_n      (eth_rst_n_w),
      .eth_clocks_gtx (gtx_w),
      .eth_tx_en      (en_w),
      .eth_tx_data    (data_w)
   );

   assign mon_rst_n = sel_w ? eth_rst_n_w : eth_rst_n;
   assign mon_gtx   = sel_w ? gtx_w       : gtx;
   assign mon_en    = sel_w ? en_w        : en;
   assign mon_data  = sel_w ? data_w      : data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bit-serial reference CRC-32, reflected, LSB first.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic build_frame(input logic [31:0] cnt);
      logic [31:0] c;
      for (int i = 0; i < 72; i++) exp_frm[i] = 8'h00;
      for (int i = 0; i < 7; i++) exp_frm[i] = 8'h55;
      exp_frm[7] = 8'hD5;
      for (int i = 8; i < 14; i++) exp_frm[i] = 8'hFF;
      for (int i = 0; i < 6; i++) exp_frm[14+i] = src_mac[i];
      exp_frm[20] = 8'h88;
      exp_frm[21] = 8'hB5;
      for (int i = 0; i < 9; i++) exp_frm[22+i] = hello_str[i];
      exp_frm[31] = cnt[31:24];
      exp_frm[32] = cnt[23:16];
      exp_frm[33] = cnt[15:8];
      exp_frm[34] = cnt[7:0];
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 68; i++) c = crc_step(c, exp_frm[i]);
      c = ~c;
      exp_frm[68] = c[7:0];
      exp_frm[69] = c[15:8];
      exp_frm[70] = c[23:16];
      exp_frm[71] = c[31:24];
   endtask

   task automatic check_frame(input string tag, input logic [31:0] cnt);
      logic [31:0] r;
      build_frame(cnt);
      for (int i = 0; i < 72; i++) begin
         check($sformatf("%s byte %0d", tag, i), {24'h0, got_frm[i]}, {24'h0, exp_frm[i]});
      end
      r = 32'hFFFF_FFFF;
      for (int i = 8; i < 72; i++) r = crc_step(r, got_frm[i]);
      check({tag, " residue"}, r, 32'hDEBB_20E3);
   endtask

   // Entered at the negedge where tx_en has just risen; samples each byte mid-slot.
   task automatic capture_frame(input string tag);
      int bad = 0;
      for (int i = 0; i < 72; i++) begin
         @(negedge clk);
         got_frm[i] = mon_data;
         if (!mon_en || !mon_gtx) bad++;
         @(negedge clk);
      end
      check({tag, " tx_en held"}, bad, 0);
      check({tag, " tx_en drop"}, 32'(mon_en), 0);
   endtask

   task automatic wait_frame(input string tag, input int limit, output int idle);
      int n    = 0;
      int dbad = 0;
      while (!mon_en && n < limit) begin
         if (mon_data !== 8'h00) dbad++;
         @(negedge clk);
         n++;
      end
      check({tag, " start seen"}, 32'(mon_en), 1);
      check({tag, " idle data"}, dbad, 0);
      idle      = n;
      frm_start = cyc;
   endtask

   // Called right after reset release at a negedge; clock 0 follows synchronised release.
   task automatic startup(input string tag);
      int rst_rise = -1;
      int en_rise  = -1;
      int gbad     = 0;
      @(posedge clk);
      @(posedge clk);
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (mon_gtx !== c[0]) gbad++;
         if (rst_rise < 0 && mon_rst_n) rst_rise = c;
         if (mon_en) begin
            en_rise = c;
            break;
         end
      end
      frm_start = cyc;
      check({tag, " eth_rst_n release clock"}, rst_rise, 32);
      check({tag, " first tx_en clock"}, en_rise, 48);
      check({tag, " gtx toggling"}, gbad, 0);
   endtask

   initial begin
      int idle;
      int f0;
      cpu_reset = 1'b0;
      rst_w     = 1'b0;
      sel_w     = 1'b0;
      repeat (5) @(negedge clk);
      check("reset eth_rst_n", 32'(eth_rst_n), 0);
      check("reset tx_en", 32'(en), 0);
      check("reset tx_data", 32'(data), 0);
      check("reset gtx", 32'(gtx), 0);
      check("reset serial_tx", 32'(serial_tx), 1);

      cpu_reset = 1'b1;
      startup("boot");
      f0 = frm_start;
      capture_frame("frame0");
      check_frame("frame0", 32'h0000_0000);

      wait_frame("frame1", 5000, idle);
      check("frame1 ifg length", 32'(idle >= 24), 1);
      check("frame1 spacing", frm_start - f0, 4000);
      capture_frame("frame1");
      check_frame("frame1", 32'h0000_0001);

      // Assert reset in the middle of the third frame's payload.
      wait_frame("frame2", 5000, idle);
      repeat (80) @(negedge clk);
      check("frame2 in flight", 32'(en), 1);
      @(posedge clk);
      #1 cpu_reset = 1'b0;
      #1;
      check("midreset tx_en", 32'(en), 0);
      check("midreset eth_rst_n", 32'(eth_rst_n), 0);
      check("midreset tx_data", 32'(data), 0);
      check("midreset gtx", 32'(gtx), 0);
      check("midreset serial_tx", 32'(serial_tx), 1);
      repeat (4) @(negedge clk);
      cpu_reset = 1'b1;
      startup("restart");
      capture_frame("restart");
      check_frame("restart", 32'h0000_0000);
      check("restart serial_tx", 32'(serial_tx), 1);

      // Counter wrap on the preloaded instance (100-slot period).
      sel_w = 1'b1;
      @(negedge clk);
      rst_w = 1'b1;
      startup("wrap boot");
      f0 = frm_start;
      capture_frame("wrap0");
      check_frame("wrap0", 32'hFFFF_FFFF);
      wait_frame("wrap1", 1000, idle);
      check("wrap1 spacing", frm_start - f0, 200);
      capture_frame("wrap1");
      check_frame("wrap1", 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hello_eth.md
# hello_eth

Self-contained "hello world" Ethernet transmitter used as the SP605 board top-level bring-up design. After reset it releases the PHY reset, then periodically broadcasts a fixed Ethernet II frame on the GMII transmit pins. Each frame carries an ASCII greeting and a frame counter, terminated by a valid FCS. UART pins exist for board pin compatibility; the block does not use them.

## Interface
Parameters:
- `SRC_MAC`, 48'h10E2D5000000, source MAC address inserted in every frame.
- `ETHERTYPE`, 16'h88B5, EtherType field (local experimental).
- `CLK_DIV`, 2, clock cycles per GMII byte slot (fixed at 2; other values unsupported).
- `PHY_RST_CYCLES`, 32, clocks that `eth_rst_n` is held low after reset.
- `START_SLOTS`, 8, byte slots from PHY reset release to the first frame.
- `FRAME_PERIOD`, 2000, byte slots between successive frame starts (≥84).

Ports:
- `clk200_p`  in  1  system clock, 200 MHz. This is the single clock of the block; all logic runs on its rising edge.
- `clk200_n`  in  1  complementary clock leg; pin compatibility only, unused.
- `cpu_reset`  in  1  reset, asynchronous assert, active-low. Deassertion is synchronised to `clk200_p` through 2 flops.
- `serial_rx`, `serial_cts`, `serial_rts`  in  1 each  UART inputs, ignored.
- `serial_tx`  out  1  constant 1 (UART idle).
- `eth_rst_n`  out  1  PHY reset, active-low.
- `eth_clocks_gtx`  out  1  GMII transmit clock to the PHY, equal to clk/2.
- `eth_tx_en`  out  1  GMII transmit enable.
- `eth_tx_data`  out  8  GMII transmit byte.

## Operation
- Reset values: `eth_rst_n`=0, `eth_tx_en`=0, `eth_tx_data`=0, `eth_clocks_gtx`=0, `serial_tx`=1, frame counter=0.
- State machine: PHY_RST, WAIT, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG.
  - PHY_RST: hold for `PHY_RST_CYCLES` clocks, then drive `eth_rst_n`=1 and go to WAIT.
  - WAIT: count byte slots. After `START_SLOTS` (first frame) or until `FRAME_PERIOD` slots have elapsed since the previous frame start, go to PREAMBLE.
- Byte stream on the wire, 72 bytes, `eth_tx_en`=1 throughout:
  - preamble: 7×0x55
  - SFD: 0xD5
  - destination MAC: 6×0xFF
  - `SRC_MAC`, MSB byte first
  - `ETHERTYPE`, MSB first
  - payload: 46 bytes
  - FCS: 4 bytes
- Payload:
  - "Hello ETH" = 48 65 6C 6C 6F 20 45 54 48
  - 32-bit frame counter, big-endian
  - 33 bytes of 0x00
- FCS:
  - IEEE CRC-32, reflected, polynomial 0x04C11DB7, register initialised to 0xFFFFFFFF.
  - Computed over destination MAC through the end of the payload, processing each byte LSB first.
  - Transmitted as the complemented register, low byte first.
- IFG: `eth_tx_en`=0 and `eth_tx_data`=0 for at least 12 slots, then return to WAIT.
- The frame counter increments by 1 after each frame's FCS and wraps 0xFFFFFFFF→0.
- Reset assertion at any point returns all outputs to reset values within the same clock edge (asynchronous) and truncates any frame in flight.

## Timing
- Byte slot = 2 clocks.
  - First cycle of a slot: `eth_clocks_gtx`=0, and `eth_tx_data`/`eth_tx_en` update on this edge.
  - Second cycle: `eth_clocks_gtx`=1.
  - The PHY samples on the gtx rising edge, in mid-slot.
- `eth_clocks_gtx` toggles continuously once reset is released, including during PHY_RST.
- With defaults, the first preamble byte appears at clock 32 + 2·8 = 48 after synchronised reset release. The frame ends 144 clocks later.
- CRC latency: the register is updated in the slot its byte is driven. The FCS bytes follow the last payload byte with no gap.

## Structure
- Shared package `hello_eth_pkg`:
  - state enum
  - preamble/SFD constants
  - greeting byte ROM
  - CRC polynomial and init value
  - frame field offsets (0, 7, 8, 14, 20, 22, 68)
- Sub-module `crc32_d8`: combinational 8-bit-per-step reflected CRC-32 next-state function. Inputs: current CRC and data byte. Output: next CRC.
- Top module contains the reset synchroniser, slot divider, FSM, byte mux and counters.

## Test plan
- Reset release → `eth_rst_n` low for exactly 32 clocks, then high; `eth_tx_en` low until clock 48.
- First frame:
  - bytes 0–7 = 55×7, D5
  - bytes 8–13 = FF
  - bytes 14–19 = 10 E2 D5 00 00 00
  - bytes 20–21 = 88 B5
  - bytes 22–30 = the "Hello ETH" bytes
  - bytes 31–34 = 00 00 00 00
- FCS check: CRC-32 register run over bytes 8..71 inclusive, without final complement → residue 0xDEBB20E3. Bytes 68–71 must also match a software model.
- Second frame starts exactly 2000 slots after the first; its counter bytes are 00 00 00 01; the IFG of ≥12 slots has `eth_tx_en`=0.
- Preloaded counter 0xFFFFFFFF → frame carries FF FF FF FF; the next frame carries 00 00 00 00.
- Reset driven low mid-payload → `eth_tx_en`=0 and `eth_rst_n`=0 immediately; the sequence restarts from PHY_RST with counter 0. `serial_tx`=1 throughout.
